// File: rtl/fixed_point_pkg.sv
// Shared constants, FSM encoding and helpers for the 16-bit fixed-point word:
// 13-bit signed mantissa in [15:3], 3-bit fraction-bit count in [2:0].
package fixed_point_pkg;

    localparam int WORD_W       = 16;
    localparam int MANT_W       = 13;
    localparam int SCALE_W      = 3;
    localparam int SCALE_MAX    = 7;
    localparam int MANT_POS_MAX = 4095;
    localparam int MANT_NEG_MAG = 4096;
    localparam int DIV_W        = 27;
    localparam int REM_W        = 14;

    // Saturated words: largest positive / most negative mantissa at scale 0
    localparam logic [WORD_W-1:0] WORD_POS_SAT = 16'h7FF8;
    localparam logic [WORD_W-1:0] WORD_NEG_SAT = 16'h8000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIVIDE = 2'd1,
        ST_NORM   = 2'd2,
        ST_DONE   = 2'd3
    } div_state_t;

    // Magnitude of a signed mantissa; -4096 maps to 13'h1000 read as unsigned
    function automatic logic [MANT_W-1:0] mant_abs(input logic [MANT_W-1:0] m);
        return m[MANT_W-1] ? (-m) : m;
    endfunction

endpackage

// File: rtl/fixed_point_divider_if.sv
// Start/busy/done bus of the fixed-point divider.
interface fixed_point_divider_if;
    import fixed_point_pkg::*;

    logic              start;
    logic [WORD_W-1:0] dividend;
    logic [WORD_W-1:0] divisor;
    logic              busy;
    logic              done;
    logic [WORD_W-1:0] quotient;
    logic              overflow;
    logic              div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, overflow, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, overflow, div_by_zero
    );

endinterface

// File: rtl/fixed_point_normalizer.sv
// Packs a 27-bit unsigned magnitude (scale 7) plus sign back into the word
// format, dropping fraction bits until the mantissa fits, else saturating.
module fixed_point_normalizer
    import fixed_point_pkg::*;
(
    input  logic [DIV_W-1:0]  q,
    input  logic              sign,
    output logic [WORD_W-1:0] word,
    output logic              overflow
);

    logic [DIV_W-1:0]   limit;
    logic [DIV_W-1:0]   shifted [SCALE_MAX+1];
    logic [SCALE_MAX:0] fits;
    logic [MANT_W-1:0]  mag;
    logic [MANT_W-1:0]  mant;
    logic [SCALE_W-1:0] k;

    // Negative results may reach -4096, positive ones only +4095
    assign limit = sign ? DIV_W'(MANT_NEG_MAG) : DIV_W'(MANT_POS_MAX);

    generate
        for (genvar gi = 0; gi <= SCALE_MAX; gi++) begin : g_shift
            assign shifted[gi] = q >> gi;
            assign fits[gi]    = (shifted[gi] <= limit);
        end
    endgenerate

    // Smallest right shift that fits keeps the most fraction bits
    always_comb begin
        mag = '0;
        k   = '0;
        for (int i = SCALE_MAX; i >= 0; i--) begin
            if (fits[i]) begin
                k   = SCALE_W'(i);
                mag = shifted[i][MANT_W-1:0];
            end
        end
        overflow = ~|fits;
        mant     = sign ? (-mag) : mag;
        if (overflow) begin
            word = sign ? WORD_NEG_SAT : WORD_POS_SAT;
        end else begin
            word = {mant, SCALE_W'(SCALE_MAX) - k};
        end
    end

endmodule

// File: rtl/fixed_point_divider.sv
// Fixed-latency restoring divider for the fixed-point word: 27 quotient bits,
// one per cycle, then a normalise cycle and a one-cycle done pulse.
module fixed_point_divider
    import fixed_point_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    fixed_point_divider_if.slave  bus
);

    div_state_t         state_reg;
    logic [4:0]         count_reg;
    logic [DIV_W-1:0]   work_reg;
    logic [REM_W-1:0]   rem_reg;
    logic [MANT_W-1:0]  mag_b_reg;
    logic               sign_reg;
    logic               a_neg_reg;
    logic               b_zero_reg;
    logic               busy_reg;
    logic               done_reg;
    logic [WORD_W-1:0]  quotient_reg;
    logic               overflow_reg;
    logic               div_by_zero_reg;

    logic [MANT_W-1:0]  na, nb;
    logic [SCALE_W-1:0] sa, sb;
    logic [3:0]         shift_e;
    logic [DIV_W-1:0]   work_init;
    logic               accept;
    logic [REM_W:0]     trial;
    logic [REM_W:0]     diff;
    logic               rem_ge;
    logic [WORD_W-1:0]  norm_word;
    logic               norm_ovf;

    assign na = bus.dividend[WORD_W-1:SCALE_W];
    assign sa = bus.dividend[SCALE_W-1:0];
    assign nb = bus.divisor[WORD_W-1:SCALE_W];
    assign sb = bus.divisor[SCALE_W-1:0];

    // Pre-shift so the raw quotient comes out at scale 7 (e spans 0..14)
    assign shift_e   = 4'(SCALE_MAX) + {1'b0, sb} - {1'b0, sa};
    assign work_init = DIV_W'(mant_abs(na)) << shift_e;
    assign accept    = bus.start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));

    // Restoring step: dividend MSB shifts into the remainder each cycle
    assign trial  = {rem_reg, work_reg[DIV_W-1]};
    assign diff   = trial - {{(REM_W+1-MANT_W){1'b0}}, mag_b_reg};
    assign rem_ge = ~diff[REM_W];

    fixed_point_normalizer u_norm (
        .q        (work_reg),
        .sign     (sign_reg),
        .word     (norm_word),
        .overflow (norm_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            count_reg       <= '0;
            work_reg        <= '0;
            rem_reg         <= '0;
            mag_b_reg       <= '0;
            sign_reg        <= 1'b0;
            a_neg_reg       <= 1'b0;
            b_zero_reg      <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            quotient_reg    <= '0;
            overflow_reg    <= 1'b0;
            div_by_zero_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (accept) begin
                work_reg   <= work_init;
                rem_reg    <= '0;
                mag_b_reg  <= mant_abs(nb);
                sign_reg   <= na[MANT_W-1] ^ nb[MANT_W-1];
                a_neg_reg  <= na[MANT_W-1];
                b_zero_reg <= (nb == '0);
                count_reg  <= '0;
                busy_reg   <= 1'b1;
                state_reg  <= ST_DIVIDE;
            end else begin
                case (state_reg)
                    ST_DIVIDE: begin
                        rem_reg   <= rem_ge ? diff[REM_W-1:0] : trial[REM_W-1:0];
                        work_reg  <= {work_reg[DIV_W-2:0], rem_ge};
                        count_reg <= count_reg + 5'd1;
                        if (count_reg == 5'(DIV_W - 1)) begin
                            state_reg <= ST_NORM;
                        end
                    end
                    ST_NORM: begin
                        // A zero divisor still ran the full loop; its result is forced here
                        if (b_zero_reg) begin
                            quotient_reg    <= a_neg_reg ? WORD_NEG_SAT : WORD_POS_SAT;
                            overflow_reg    <= 1'b0;
                            div_by_zero_reg <= 1'b1;
                        end else begin
                            quotient_reg    <= norm_word;
                            overflow_reg    <= norm_ovf;
                            div_by_zero_reg <= 1'b0;
                        end
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= ST_DONE;
                    end
                    ST_DONE: begin
                        state_reg <= ST_IDLE;
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.busy        = busy_reg;
    assign bus.done        = done_reg;
    assign bus.quotient    = quotient_reg;
    assign bus.overflow    = overflow_reg;
    assign bus.div_by_zero = div_by_zero_reg;

endmodule

// File: tb/tb_fixed_point_divider.sv
// Self-checking bench for fixed_point_divider: directed word-format cases,
// random operands against a value-level model, back-to-back, busy and reset.
module tb_fixed_point_divider;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    fixed_point_divider_if bus ();

    fixed_point_divider dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Returns {div_by_zero, overflow, word}: picks the largest scale s whose
    // truncated |a/b| * 2^s fits the signed mantissa range.
    function automatic logic [17:0] ref_div(input logic [15:0] a, input logic [15:0] b);
        logic [12:0] fa, fb, m13;
        int          na, nb, sa, sb;
        longint      ma, mb, m, lim;
        bit          neg;
        fa = a[15:3];
        fb = b[15:3];
        na = int'($signed(fa));
        nb = int'($signed(fb));
        sa = int'(a[2:0]);
        sb = int'(b[2:0]);
        ma = (na < 0) ? -na : na;
        mb = (nb < 0) ? -nb : nb;
        if (mb == 0) return {1'b1, 1'b0, (na < 0) ? 16'h8000 : 16'h7FF8};
        neg = (na < 0) != (nb < 0);
        lim = neg ? 4096 : 4095;
        for (int s = 7; s >= 0; s--) begin
            m = (ma << (s + sb)) / (mb << sa);
            if (m <= lim) begin
                m13 = 13'(neg ? -m : m);
                return {2'b00, m13, 3'(s)};
            end
        end
        return {1'b0, 1'b1, neg ? 16'h8000 : 16'h7FF8};
    endfunction

    task automatic launch(input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
    endtask

    // Counts cycles after the accepting edge until done; scrambles operands
    // meanwhile. lat = -1 if done never arrives within the bound.
    task automatic wait_done(output int lat, output bit busy_ok);
        lat     = -1;
        busy_ok = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            bus.start    = 1'b0;
            bus.dividend = 16'($urandom);
            bus.divisor  = 16'($urandom);
            if (bus.done === 1'b1) begin
                lat = n;
                if (bus.busy !== 1'b0) busy_ok = 1'b0;
                break;
            end
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({bus.busy, bus.done, bus.overflow, bus.div_by_zero} !== 4'b0000) begin
            $display("FAIL reset_flags busy/done/ovf/dz=%b required 0000",
                     {bus.busy, bus.done, bus.overflow, bus.div_by_zero});
        end else pass_cnt++;
        total_cnt++;
        if (bus.quotient !== 16'h0000) begin
            $display("FAIL reset_quotient got %h required 0000", bus.quotient);
        end else pass_cnt++;
        rst = 1'b0;
        $display("reset released");
    endtask

    task automatic test_directed();
        logic [15:0] va [11] = '{16'h0018, 16'hFFE8, 16'h0320, 16'h7FF8, 16'h7FF8, 16'h8000,
                                 16'h0000, 16'h0000, 16'h8000, 16'h8000, 16'h0008};
        logic [15:0] vb [11] = '{16'h0010, 16'h0010, 16'h0008, 16'h000F, 16'h0005, 16'h0005,
                                 16'h0010, 16'hFFF8, 16'h0008, 16'hFFF8, 16'h0018};
        logic [15:0] vq [11] = '{16'h0607, 16'hFA07, 16'h6405, 16'h7FF8, 16'h7FF8, 16'h8000,
                                 16'h0007, 16'h0007, 16'h8000, 16'h7FF8, 16'h0157};
        logic [1:0]  vf [11] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b10,
                                 2'b00, 2'b00, 2'b00, 2'b01, 2'b00};
        int lat;
        bit busy_ok;
        for (int i = 0; i < 11; i++) begin
            launch(va[i], vb[i]);
            wait_done(lat, busy_ok);
            $display("directed a=%h b=%h q=%h ovf=%b dz=%b lat=%0d",
                     va[i], vb[i], bus.quotient, bus.overflow, bus.div_by_zero, lat);
            total_cnt++;
            if (lat !== 29) $display("FAIL dir_latency case %0d got %0d required 29", i, lat);
            else pass_cnt++;
            total_cnt++;
            if (!busy_ok) $display("FAIL dir_busy case %0d busy got wrong level required 1 then 0", i);
            else pass_cnt++;
            total_cnt++;
            if (bus.quotient !== vq[i])
                $display("FAIL dir_quotient case %0d got %h required %h", i, bus.quotient, vq[i]);
            else pass_cnt++;
            total_cnt++;
            if ({bus.div_by_zero, bus.overflow} !== vf[i])
                $display("FAIL dir_flags case %0d dz/ovf got %b required %b",
                         i, {bus.div_by_zero, bus.overflow}, vf[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        logic [15:0] a, b;
        logic [17:0] exp;
        int lat;
        bit busy_ok;
        for (int i = 0; i < 30; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            if ($urandom_range(0, 7) == 0) b[15:3] = '0;
            else if ($urandom_range(0, 2) == 0) b[15:3] = 13'($urandom_range(0, 15)) ^ {13{b[15]}};
            exp = ref_div(a, b);
            launch(a, b);
            wait_done(lat, busy_ok);
            $display("random a=%h b=%h q=%h ovf=%b dz=%b lat=%0d",
                     a, b, bus.quotient, bus.overflow, bus.div_by_zero, lat);
            total_cnt++;
            if (lat !== 29 || !busy_ok)
                $display("FAIL rnd_timing a=%h b=%h lat got %0d busy_ok %0b required 29 1",
                         a, b, lat, busy_ok);
            else pass_cnt++;
            total_cnt++;
            if ({bus.div_by_zero, bus.overflow, bus.quotient} !== exp)
                $display("FAIL rnd_result a=%h b=%h got dz/ovf/q %b/%b/%h required %b/%b/%h",
                         a, b, bus.div_by_zero, bus.overflow, bus.quotient,
                         exp[17], exp[16], exp[15:0]);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] a2, b2;
        logic [17:0] exp;
        int lat;
        bit busy_ok;
        launch(16'h0018, 16'h0010);
        wait_done(lat, busy_ok);
        total_cnt++;
        if (lat !== 29 || bus.quotient !== 16'h0607)
            $display("FAIL b2b_first lat/q got %0d/%h required 29/0607", lat, bus.quotient);
        else pass_cnt++;
        // Issue the next start in the DONE cycle itself
        a2 = 16'hFFE8;
        b2 = 16'h0018;
        exp = ref_div(a2, b2);
        bus.dividend = a2;
        bus.divisor  = b2;
        bus.start    = 1'b1;
        wait_done(lat, busy_ok);
        $display("back_to_back a=%h b=%h q=%h lat=%0d", a2, b2, bus.quotient, lat);
        total_cnt++;
        if (lat !== 29 || !busy_ok)
            $display("FAIL b2b_second_latency got %0d busy_ok %0b required 29 1", lat, busy_ok);
        else pass_cnt++;
        total_cnt++;
        if ({bus.div_by_zero, bus.overflow, bus.quotient} !== exp)
            $display("FAIL b2b_second_result got %h required %h", bus.quotient, exp[15:0]);
        else pass_cnt++;
    endtask

    task automatic test_start_while_busy();
        logic [17:0] exp;
        int dones = 0;
        int first = -1;
        exp = ref_div(16'h0320, 16'h0008);
        launch(16'h0320, 16'h0008);
        for (int n = 1; n <= 70; n++) begin
            @(negedge clk);
            bus.start = (n == 5 || n == 15 || n == 28);
            if (bus.start) begin
                bus.dividend = 16'($urandom);
                bus.divisor  = 16'($urandom);
            end
            if (bus.done === 1'b1) begin
                dones++;
                if (first < 0) first = n;
            end
        end
        $display("busy_ignore first_done=%0d dones=%0d q=%h", first, dones, bus.quotient);
        total_cnt++;
        if (first !== 29 || dones !== 1)
            $display("FAIL busy_ignore first/count got %0d/%0d required 29/1", first, dones);
        else pass_cnt++;
        total_cnt++;
        if (bus.quotient !== exp[15:0])
            $display("FAIL busy_ignore_result got %h required %h", bus.quotient, exp[15:0]);
        else pass_cnt++;
    endtask

    task automatic test_reset_abort();
        int dones = 0;
        int lat;
        bit busy_ok;
        launch(16'h0008, 16'h0018);
        for (int n = 1; n <= 9; n++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        total_cnt++;
        if ({bus.busy, bus.done, bus.overflow, bus.div_by_zero, bus.quotient} !== 20'h0)
            $display("FAIL abort_outputs busy/done/ovf/dz/q got %b%b%b%b/%h required 0000/0000",
                     bus.busy, bus.done, bus.overflow, bus.div_by_zero, bus.quotient);
        else pass_cnt++;
        rst = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
        end
        $display("reset_abort stray_dones=%0d", dones);
        total_cnt++;
        if (dones !== 0) $display("FAIL abort_no_done got %0d dones required 0", dones);
        else pass_cnt++;
        launch(16'h0018, 16'h0010);
        wait_done(lat, busy_ok);
        $display("after_abort q=%h lat=%0d", bus.quotient, lat);
        total_cnt++;
        if (lat !== 29 || bus.quotient !== 16'h0607)
            $display("FAIL abort_fresh lat/q got %0d/%h required 29/0607", lat, bus.quotient);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_start_while_busy();
        test_reset_abort();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/fixed_point_divider.md
# fixed_point_divider

Sequential divider for the ODE solver's 16-bit fixed-point word: 13-bit signed mantissa in bits [15:3] and 3-bit scale (fraction-bit count) in bits [2:0], value = mantissa / 2^scale. It is the inverse operation of the combinational multiplier on the same word format. The solver datapath uses it for step-size and coefficient divisions. It is a start/busy/done iterative shift-subtract unit with fixed latency, normalisation back into the word format, and saturation.

## Interface
- WORD_W, 16, operand/result word width
- MANT_W, 13, signed mantissa width
- SCALE_W, 3, scale field width
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  request; accepted only in IDLE or DONE
- dividend  in  16  fixed-point word a
- divisor  in  16  fixed-point word b
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse; result valid
- quotient  out  16  fixed-point result word, held until next done or reset
- overflow  out  1  result saturated; valid with done, held
- div_by_zero  out  1  divisor mantissa was 0; valid with done, held

## Operation
- States: IDLE, DIVIDE, NORM, DONE.
- Accept (start=1 in IDLE/DONE):
  - Latch Na, sa, Nb, sb.
  - sign = Na[12] xor Nb[12].
  - Latch magnitudes |Na|, |Nb| (≤ 4096).
  - e = 7 + sb − sa (0..14).
  - 27-bit work dividend = |Na| << e.
  - Clear the 14-bit remainder.
  - Go to DIVIDE.
  - Input changes after acceptance are ignored.
- DIVIDE:
  - Exactly 27 cycles of restoring division, one quotient bit per cycle, MSB first.
  - Remainder 14 bits.
  - Raw magnitude q is 27 bits, truncated toward zero.
- NORM (1 cycle, combinational normaliser, registered outputs):
  - Limit L = 4095 if sign=0, 4096 if sign=1.
  - Pick the smallest k in 0..7 with (q >> k) ≤ L.
  - Mantissa = ±(q >> k), scale = 7 − k.
  - If no k fits: mantissa = +4095 or −4096 per sign, scale 0, overflow=1.
  - q = 0 gives word 16'h0007.
- Divide by zero (Nb = 0):
  - DIVIDE still runs (fixed latency).
  - Result = 16'h7FF8 if Na ≥ 0, else 16'h8000.
  - div_by_zero=1, overflow=0.
- DONE:
  - done=1 for one cycle.
  - Next state is IDLE, or DIVIDE if start is accepted in the same cycle (back-to-back).

## Timing
- Reset values: busy=0, done=0, quotient=16'h0000, overflow=0, div_by_zero=0, state IDLE.
- start sampled at edge T:
  - busy=1 from T+1 through T+28 (27 DIVIDE + 1 NORM cycles).
  - done=1, busy=0, result valid in cycle T+29.
- Latency is fixed at 29 cycles regardless of operands.
- start while busy=1 is ignored and never queued.
- start in the DONE cycle is accepted; the next done follows 29 cycles later with no idle gap.
- rst has priority over everything:
  - Mid-operation: abort, return to IDLE, clear outputs next cycle.
  - No done is issued for the aborted operation.
- quotient, overflow and div_by_zero change only on the edge that raises done, or on reset.

## Structure
- Shared package fixed_point_pkg holds:
  - WORD_W, MANT_W, SCALE_W.
  - SCALE_MAX=7, MANT_POS_MAX=4095, MANT_NEG_MAG=4096, DIV_W=27, REM_W=14.
  - State encoding for IDLE/DIVIDE/NORM/DONE.
  - The multiplier migrates to these constants.
- Sub-module fixed_point_normalizer (purely combinational):
  - Inputs: 27-bit q, sign.
  - Outputs: 16-bit word, overflow.
  - Reusable by future adder/accumulator blocks.

## Test plan
- a=16'h0018 (3.0), b=16'h0010 (2.0), start pulse -> done at T+29, quotient=16'h0607 (192/128=1.5), overflow=0, div_by_zero=0.
- a=16'hFFE8 (−3.0), b=16'h0010 -> quotient=16'hFA07 (−1.5).
- a=16'h0320 (100), b=16'h0008 (1) -> normalise k=2, quotient=16'h6405 (3200/32), overflow=0.
- a=16'h7FF8 (4095), b=16'h000F (1/128) -> quotient=16'h7FF8, overflow=1. Repeat with b=16'h0005 (zero) -> 16'h7FF8, div_by_zero=1, overflow=0.
- Back-to-back: second start in the DONE cycle -> second done exactly 29 cycles later. start pulses while busy -> ignored, no extra done.
- rst asserted at T+10 of an operation -> IDLE next cycle, all outputs 0, no done. A fresh start afterwards completes normally in 29 cycles.
